// File: rtl/uart_protocol_rx_if.sv
// Byte-stream input and frame-result output bundle of the command-frame parser.
// master: byte source / frame consumer; slave: the parser.
interface uart_protocol_rx_if;
   logic       uart_rx_done;
   logic [7:0] uart_rx_data;
   logic       recv_done;
   logic       crc_err;
   logic       frame_err;
   logic       rx_busy;
   logic [7:0] rev_data0;
   logic [7:0] rev_data1;
   logic [7:0] rev_data2;
   logic [7:0] rev_data3;
   logic [7:0] rev_data4;
   logic [7:0] rev_data5;
   logic [7:0] rev_data6;
   logic [7:0] rev_data7;
   logic [7:0] rev_data8;
   logic [7:0] rev_data9;
   logic [7:0] rev_data10;

   modport master (
      output uart_rx_done, uart_rx_data,
      input  recv_done, crc_err, frame_err, rx_busy,
      input  rev_data0, rev_data1, rev_data2, rev_data3, rev_data4, rev_data5,
      input  rev_data6, rev_data7, rev_data8, rev_data9, rev_data10
   );

   modport slave (
      input  uart_rx_done, uart_rx_data,
      output recv_done, crc_err, frame_err, rx_busy,
      output rev_data0, rev_data1, rev_data2, rev_data3, rev_data4, rev_data5,
      output rev_data6, rev_data7, rev_data8, rev_data9, rev_data10
   );
endinterface

// File: rtl/uart_protocol_rx.sv
// Command-frame parser: HEAD, 11 payload bytes, CRC-8 (poly 0x07), TAIL.
// Publishes the payload on a valid frame; flags CRC, tail and inter-byte timeout errors.
//
// state     | meaning
// S_IDLE    | waiting for HEAD_BYTE, everything else discarded
// S_PAYLOAD | collecting payload bytes 0..10 into the shadow buffer
// S_CRC     | next byte is the received CRC
// S_TAIL    | next byte is the tail; decides recv_done / crc_err / frame_err
module uart_protocol_rx #(
   parameter int         CLK_FREQ      = 50000000,
   parameter int         UART_BPS      = 115200,
   parameter logic [7:0] HEAD_BYTE     = 8'h80,
   parameter logic [7:0] TAIL_BYTE     = 8'h55,
   parameter int         TIMEOUT_BYTES = 3
) (
   input  logic                  clk_50M,
   input  logic                  rst_n,
   uart_protocol_rx_if.slave     bus
);

   localparam int          TIMEOUT_CYC = (CLK_FREQ / UART_BPS) * 10 * TIMEOUT_BYTES;
   localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT_CYC);

   typedef enum logic [1:0] {
      S_IDLE,
      S_PAYLOAD,
      S_CRC,
      S_TAIL
   } state_t;

   state_t      state, state_nxt;
   logic [3:0]  idx;
   logic [7:0]  crc_q;
   logic [7:0]  crc_nxt;
   logic        crc_ok;
   logic [15:0] to_cnt;
   logic [7:0]  shadow [0:10];
   logic [7:0]  rev    [0:10];
   logic        recv_done_q, crc_err_q, frame_err_q;

   logic        start_frame, load_pl, fire_ok, fire_crc, fire_frame, to_hit;

   function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] din);
      logic [7:0] c;
      c = crc ^ din;
      for (int i = 0; i < 8; i++)
         c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
      return c;
   endfunction

   assign crc_nxt = crc8_step(crc_q, bus.uart_rx_data);

   // A strobe in the same cycle as the terminal count wins over the timeout.
   assign to_hit = (state != S_IDLE) && !bus.uart_rx_done && ((to_cnt + 16'd1) == TIMEOUT_CNT);

   always_comb begin
      state_nxt   = state;
      start_frame = 1'b0;
      load_pl     = 1'b0;
      fire_ok     = 1'b0;
      fire_crc    = 1'b0;
      fire_frame  = 1'b0;
      if (bus.uart_rx_done) begin
         case (state)
            S_IDLE: begin
               if (bus.uart_rx_data == HEAD_BYTE) begin
                  start_frame = 1'b1;
                  state_nxt   = S_PAYLOAD;
               end
            end
            S_PAYLOAD: begin
               load_pl = 1'b1;
               if (idx == 4'd10)
                  state_nxt = S_CRC;
            end
            S_CRC: state_nxt = S_TAIL;
            S_TAIL: begin
               state_nxt = S_IDLE;
               if (bus.uart_rx_data != TAIL_BYTE)
                  fire_frame = 1'b1;
               else if (crc_ok)
                  fire_ok = 1'b1;
               else
                  fire_crc = 1'b1;
            end
            default: state_nxt = S_IDLE;
         endcase
      end else if (to_hit) begin
         state_nxt  = S_IDLE;
         fire_frame = 1'b1;
      end
   end

   always_ff @(posedge clk_50M) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         idx         <= 4'd0;
         crc_q       <= 8'h00;
         crc_ok      <= 1'b0;
         to_cnt      <= 16'd0;
         recv_done_q <= 1'b0;
         crc_err_q   <= 1'b0;
         frame_err_q <= 1'b0;
         for (int i = 0; i < 11; i++) begin
            shadow[i] <= 8'h00;
            rev[i]    <= 8'h00;
         end
      end else begin
         state       <= state_nxt;
         recv_done_q <= fire_ok;
         crc_err_q   <= fire_crc;
         frame_err_q <= fire_frame;

         if (start_frame) begin
            idx   <= 4'd0;
            crc_q <= 8'h00;
         end
         if (load_pl) begin
            shadow[idx] <= bus.uart_rx_data;
            crc_q       <= crc_nxt;
            idx         <= idx + 4'd1;
         end
         if (state == S_CRC && bus.uart_rx_done)
            crc_ok <= (bus.uart_rx_data == crc_q);
         if (fire_ok)
            rev <= shadow;

         if (bus.uart_rx_done || state == S_IDLE)
            to_cnt <= 16'd0;
         else
            to_cnt <= to_cnt + 16'd1;
      end
   end

   assign bus.recv_done  = recv_done_q;
   assign bus.crc_err    = crc_err_q;
   assign bus.frame_err  = frame_err_q;
   assign bus.rx_busy    = (state != S_IDLE);
   assign bus.rev_data0  = rev[0];
   assign bus.rev_data1  = rev[1];
   assign bus.rev_data2  = rev[2];
   assign bus.rev_data3  = rev[3];
   assign bus.rev_data4  = rev[4];
   assign bus.rev_data5  = rev[5];
   assign bus.rev_data6  = rev[6];
   assign bus.rev_data7  = rev[7];
   assign bus.rev_data8  = rev[8];
   assign bus.rev_data9  = rev[9];
   assign bus.rev_data10 = rev[10];

endmodule
